adc0809_emu: RTL and testbench

Cycle-accurate emulation of an ADC0809-style 8-channel successive-approximation converter, as seen by the game CPU. It is the reading end of the analog stick path: the top level supplies 8-bit stick positions (real analog or pseudo-analog), and this block converts them. The CPU selects a channel, starts a conversion, polls EOC and reads the result, with realistic conversion latency. It sits inside the game core on the CPU I/O bus.

---
 rtl/adc0809_pkg.sv | 21 ++
 rtl/adc0809_emu_sar_core.sv | 56 +++++
 rtl/adc0809_emu.sv | 100 ++++++++++
 tb/tb_adc0809_emu.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/adc0809_pkg.sv
// Shared types and constants for the ADC0809-style converter emulation.
// Holds the FSM state encoding and the analog channel mux helper.
package adc0809_pkg;

    localparam int NCH = 8;
    localparam int DW  = 8;
    localparam int CSW = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_e;

    // Pick channel ch out of the packed analog input bus.
    function automatic logic [DW-1:0] ch_select(input logic [NCH*DW-1:0] ain,
                                                input logic [CSW-1:0]    ch);
        return ain[int'(ch)*DW +: DW];
    endfunction

endpackage

// File: rtl/adc0809_emu_sar_core.sv
// Successive-approximation register: loads a trial of 8'h80 and resolves one
// bit per step pulse against the held sample, MSB first.
module sar_core
    import adc0809_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [DW-1:0] hold_i,
    output logic [DW-1:0] sar_o,
    output logic          last_o
);

    logic [DW-1:0] sar_q, sar_d;
    logic [2:0]    bit_q, bit_d;

    // Next trial value: a new load always overrides a pending step.
    always_comb begin
        sar_d = sar_q;
        bit_d = bit_q;
        if (load_i) begin
            sar_d = 8'h80;
            bit_d = 3'd7;
        end else if (step_i) begin
            if (sar_q > hold_i) begin
                sar_d[bit_q] = 1'b0;
            end else begin
                sar_d[bit_q] = sar_q[bit_q];
            end
            if (bit_q != 3'd0) begin
                sar_d[bit_q - 3'd1] = 1'b1;
                bit_d               = bit_q - 3'd1;
            end else begin
                bit_d = bit_q;
            end
        end else begin
            sar_d = sar_q;
        end
    end

    // SAR state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sar_q <= 8'h00;
            bit_q <= 3'd0;
        end else begin
            sar_q <= sar_d;
            bit_q <= bit_d;
        end
    end

    assign sar_o  = sar_q;
    assign last_o = (bit_q == 3'd0);

endmodule

// File: rtl/adc0809_emu.sv
// ADC0809-style 8-channel converter as seen from the CPU bus: START edge
// samples a channel, EOC reports idle/valid, DOUT is gated by OE.
module adc0809_emu
    import adc0809_pkg::*;
#(
    parameter int STEP_TICKS = 8
) (
    input  logic               MCLK,
    input  logic               RESET,
    input  logic               CEN,
    input  logic [NCH*DW-1:0]  AIN,
    input  logic [CSW-1:0]     ADDR,
    input  logic               START,
    input  logic               OE,
    output logic               EOC,
    output logic [DW-1:0]      DOUT
);

    localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(STEP_TICKS - 1);

    state_e        state_q;
    logic          start_q;
    logic [TW-1:0] tick_q;
    logic [DW-1:0] hold_q;
    logic [DW-1:0] result_q;
    logic          eoc_q;
    logic          start_rise_s;
    logic          step_s;
    logic [DW-1:0] sar_s;
    logic          last_bit_s;

    // A restart on the same edge as a decision suppresses that decision.
    always_comb begin
        start_rise_s = START & ~start_q;
        step_s       = (state_q == CONVERT) && CEN && (tick_q == LAST_TICK) && !start_rise_s;
    end

    sar_core u_sar (
        .clk_i  (MCLK),
        .rst_i  (RESET),
        .load_i (start_rise_s),
        .step_i (step_s),
        .hold_i (hold_q),
        .sar_o  (sar_s),
        .last_o (last_bit_s)
    );

    // Control FSM, tick counter, sample/hold and result commit.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            tick_q   <= '0;
            hold_q   <= 8'h00;
            result_q <= 8'h00;
            eoc_q    <= 1'b1;
        end else begin
            start_q <= START;
            if (start_rise_s) begin
                hold_q  <= ch_select(AIN, ADDR);
                tick_q  <= '0;
                state_q <= CONVERT;
                eoc_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        eoc_q <= 1'b1;
                    end
                    CONVERT: begin
                        eoc_q <= 1'b0;
                        if (CEN) begin
                            if (tick_q == LAST_TICK) begin
                                tick_q <= '0;
                                if (last_bit_s) begin
                                    state_q <= DONE;
                                end
                            end else begin
                                tick_q <= tick_q + TW'(1);
                            end
                        end
                    end
                    DONE: begin
                        result_q <= sar_s;
                        state_q  <= IDLE;
                        eoc_q    <= 1'b1;
                    end
                    default: begin
                        state_q <= IDLE;
                        eoc_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign EOC  = eoc_q;
    assign DOUT = OE ? result_q : 8'h00;

endmodule

// File: tb/tb_adc0809_emu.sv
// Directed self-checking bench for adc0809_emu: latency in CEN ticks,
// result values, OE gating, restart, sample hold and reset abort.
module tb_adc0809_emu;

    logic        MCLK = 1'b0;
    logic        RESET;
    logic        CEN;
    logic [63:0] AIN;
    logic [2:0]  ADDR;
    logic        START;
    logic        OE;
    logic        EOC;
    logic [7:0]  DOUT;

    int vectors     = 0;
    int miscompares = 0;
    int n           = 0;   // CEN ticks since the START edge
    int since       = 0;   // MCLK edges since the last CEN tick
    int phase       = 0;
    bit cen_en      = 1'b1;

    adc0809_emu #(.STEP_TICKS(8)) dut (
        .MCLK  (MCLK),
        .RESET (RESET),
        .CEN   (CEN),
        .AIN   (AIN),
        .ADDR  (ADDR),
        .START (START),
        .OE    (OE),
        .EOC   (EOC),
        .DOUT  (DOUT)
    );

    always #5 MCLK = ~MCLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CEN fires on every fourth MCLK edge.
    task automatic step();
        CEN = cen_en && (phase == 3);
        @(posedge MCLK);
        #1;
        if (CEN) begin
            n++;
            since = 0;
        end else begin
            since++;
        end
        phase = (phase + 1) % 4;
    endtask

    task automatic set_ch(input int ch, input logic [7:0] v);
        AIN[ch*8 +: 8] = v;
    endtask

    task automatic start_conv(input logic [2:0] a, input bit keep_high);
        ADDR  = a;
        START = 1'b1;
        step();
        n     = 0;
        since = 0;
        if (!keep_high) START = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (EOC) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_timeout"}, {15'd0, ok}, 16'd1);
        check({tag, "_ticks"}, n[15:0], 16'd64);
        check({tag, "_commit_gap"}, since[15:0], 16'd1);
    endtask

    task automatic read_result(input string tag, input logic [7:0] exp);
        OE = 1'b1;
        #1;
        check({tag, "_dout_oe1"}, {8'd0, DOUT}, {8'd0, exp});
        OE = 1'b0;
        #1;
        check({tag, "_dout_oe0"}, {8'd0, DOUT}, 16'h0000);
    endtask

    initial begin
        RESET = 1'b1;
        CEN   = 1'b0;
        AIN   = 64'h0;
        ADDR  = 3'd0;
        START = 1'b0;
        OE    = 1'b1;
        set_ch(0, 8'h00);
        set_ch(1, 8'h11);
        set_ch(2, 8'hA5);
        set_ch(3, 8'h33);
        set_ch(4, 8'h44);
        set_ch(5, 8'h3C);
        set_ch(6, 8'h66);
        set_ch(7, 8'hFF);

        // Reset state, OE asserted
        step(); step(); step();
        check("rst_eoc", {15'd0, EOC}, 16'd1);
        check("rst_dout", {8'd0, DOUT}, 16'h0000);
        RESET = 1'b0;
        step(); step();
        check("post_rst_eoc", {15'd0, EOC}, 16'd1);
        check("post_rst_dout", {8'd0, DOUT}, 16'h0000);
        OE = 1'b0;

        // Basic conversion of channel 2
        start_conv(3'd2, 1'b0);
        check("ch2_eoc_low", {15'd0, EOC}, 16'd0);
        wait_done("ch2");
        read_result("ch2", 8'hA5);

        // Low boundary on channel 0
        start_conv(3'd0, 1'b0);
        wait_done("ch0");
        read_result("ch0", 8'h00);

        // High boundary on channel 7, START edge coincident with a CEN tick
        while (phase != 3) step();
        start_conv(3'd7, 1'b0);
        wait_done("ch7");
        read_result("ch7", 8'hFF);

        // Input change after START is ignored; START held high converts once
        set_ch(2, 8'h10);
        start_conv(3'd2, 1'b1);
        for (int i = 0; i < 20 && n < 1; i++) step();
        set_ch(2, 8'hF0);
        wait_done("hold");
        read_result("hold", 8'h10);
        for (int i = 0; i < 40; i++) step();
        check("start_held_eoc", {15'd0, EOC}, 16'd1);
        START = 1'b0;
        step();

        // Restart on channel 5 after 30 ticks of a channel 2 conversion
        set_ch(2, 8'h5A);
        start_conv(3'd2, 1'b0);
        for (int i = 0; i < 400 && n < 30; i++) step();
        read_result("mid_conv", 8'h10);
        start_conv(3'd5, 1'b0);
        check("restart_eoc_low", {15'd0, EOC}, 16'd0);
        wait_done("restart");
        read_result("restart", 8'h3C);

        // CEN stuck low stalls the conversion
        start_conv(3'd0, 1'b0);
        cen_en = 1'b0;
        for (int i = 0; i < 100; i++) step();
        check("stall_eoc", {15'd0, EOC}, 16'd0);
        check("stall_ticks", n[15:0], 16'd0);
        cen_en = 1'b1;
        wait_done("stall");
        read_result("stall", 8'h00);

        // Reset in mid-conversion abandons it
        start_conv(3'd7, 1'b0);
        for (int i = 0; i < 400 && n < 20; i++) step();
        RESET = 1'b1;
        #1;
        check("rst_mid_eoc", {15'd0, EOC}, 16'd1);
        step(); step();
        RESET = 1'b0;
        OE = 1'b1;
        #1;
        check("rst_mid_dout", {8'd0, DOUT}, 16'h0000);
        for (int i = 0; i < 300; i++) step();
        check("rst_mid_late_eoc", {15'd0, EOC}, 16'd1);
        check("rst_mid_late_dout", {8'd0, DOUT}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
